// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction/function codes, condition-code layout
// and the branch/cmov condition decode used by y86_cond_eval.
package y86_pkg;

    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // cc vector is {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    function automatic logic cond_of(input logic [3:0] fn, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[CC_ZF];
        sf = cc[CC_SF];
        of = cc[CC_OF];
        case (fn)
            C_YES:   cond_of = 1'b1;
            C_LE:    cond_of = (sf ^ of) | zf;
            C_L:     cond_of = sf ^ of;
            C_E:     cond_of = zf;
            C_NE:    cond_of = ~zf;
            C_GE:    cond_of = ~(sf ^ of);
            C_G:     cond_of = ~(sf ^ of) & ~zf;
            default: cond_of = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from a {ZF,SF,OF} flag vector.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cond
);

    logic [15:0] cond_vec;

    // One decoded condition per function code; ifun then simply selects.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cond
            assign cond_vec[gi] = cond_of(4'(gi), cc);
        end
    endgenerate

    assign cond = cond_vec[ifun];

endmodule

// File: rtl/y86_cc_unit.sv
// Y86-64 condition-code register, OPq flag generation and cnd evaluation.
// Define Y86_CC_TRACE_EN to add saturating taken/total jXX counters.
module y86_cc_unit
    import y86_pkg::*;
#(
    parameter int W     = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [W-1:0]     aluA,
    input  logic [W-1:0]     aluB,
    input  logic [W-1:0]     valE,
    input  logic             stall,
    output logic [2:0]       cc_out,
`ifdef Y86_CC_TRACE_EN
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] br_total_cnt,
`endif
    output logic             cnd
);

    logic [2:0] cc_reg;
    logic [2:0] cc_next;
    logic       set_cc;
    logic       of_next;
    logic       cond;
    logic       a_msb, b_msb, e_msb;

    assign a_msb = aluA[W-1];
    assign b_msb = aluB[W-1];
    assign e_msb = valE[W-1];

    // Only the sign bits of the operands matter for overflow.
    logic unused_opnd_bits;
    assign unused_opnd_bits = ^{aluA[W-2:0], aluB[W-2:0]};

    assign set_cc = (icode == IOPQ) && (ifun <= ALUXOR) && !stall;

    always_comb begin
        of_next = 1'b0;
        case (ifun)
            ALUADD:  of_next = (a_msb == b_msb) && (e_msb != a_msb);
            ALUSUB:  of_next = (a_msb != b_msb) && (e_msb != b_msb);
            default: of_next = 1'b0;
        endcase
        cc_next         = '0;
        cc_next[CC_ZF]  = (valE == '0);
        cc_next[CC_SF]  = e_msb;
        cc_next[CC_OF]  = of_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_reg <= CC_RESET;
        end else if (set_cc) begin
            cc_reg <= cc_next;
        end
    end

    assign cc_out = cc_reg;

    // Condition always comes from the stored flags, never this cycle's OPq.
    y86_cond_eval u_cond_eval (
        .cc   (cc_reg),
        .ifun (ifun),
        .cond (cond)
    );

    assign cnd = ((icode == IRRMOVQ) || (icode == IJXX)) ? cond : 1'b0;

`ifdef Y86_CC_TRACE_EN
    logic [CNT_W-1:0] taken_reg;
    logic [CNT_W-1:0] total_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_reg <= '0;
            total_reg <= '0;
        end else if ((icode == IJXX) && !stall) begin
            if (total_reg != '1) begin
                total_reg <= total_reg + 1'b1;
            end
            if (cnd && (taken_reg != '1)) begin
                taken_reg <= taken_reg + 1'b1;
            end
        end
    end

    assign br_taken_cnt = taken_reg;
    assign br_total_cnt = total_reg;
`endif

endmodule

// File: tb/tb_y86_cc_unit.sv
// Scoreboard bench for y86_cc_unit: stimulus queues expected flags/cnd per
// cycle, a negedge monitor pops and compares. Counter checks need Y86_CC_TRACE_EN.
module tb_y86_cc_unit;

    localparam int W  = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    icode, ifun;
    logic [W-1:0]  aluA, aluB, valE;
    logic          stall;
    logic [2:0]    cc_out;
    logic          cnd;
`ifdef Y86_CC_TRACE_EN
    logic [CW-1:0] br_taken_cnt, br_total_cnt;
`endif

    y86_cc_unit #(.W(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .icode        (icode),
        .ifun         (ifun),
        .aluA         (aluA),
        .aluB         (aluB),
        .valE         (valE),
        .stall        (stall),
        .cc_out       (cc_out),
`ifdef Y86_CC_TRACE_EN
        .br_taken_cnt (br_taken_cnt),
        .br_total_cnt (br_total_cnt),
`endif
        .cnd          (cnd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          chk_cc;
        logic [2:0]    cc;
        logic          chk_cnd;
        logic          cnd;
        logic          chk_cnt;
        logic [CW-1:0] tot;
        logic [CW-1:0] tak;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    task automatic step(input logic r, input logic st, input logic [3:0] ic,
                        input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] e);
        @(posedge clk);
        #1;
        rst = r; stall = st; icode = ic; ifun = fn; aluA = a; aluB = b; valE = e;
    endtask

    task automatic expect_cc(input string nm, input logic cc_c, input logic [2:0] c,
                             input logic cnd_c, input logic d);
        exp_t x;
        x.chk_cc = cc_c; x.cc = c; x.chk_cnd = cnd_c; x.cnd = d;
        x.chk_cnt = 1'b0; x.tot = '0; x.tak = '0;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic expect_cnt(input string nm, input logic [CW-1:0] t, input logic [CW-1:0] k);
        exp_t x;
        x.chk_cc = 1'b0; x.cc = '0; x.chk_cnd = 1'b0; x.cnd = 1'b0;
        x.chk_cnt = 1'b1; x.tot = t; x.tak = k;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: one transaction per negedge where an expectation is pending.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t  x;
                string nm;
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                $display("txn %-12s cc=%b cnd=%b", nm, cc_out, cnd);
                if (x.chk_cc) begin
                    checks++;
                    if (cc_out !== x.cc) begin
                        errors++;
                        $display("FAIL %s cc_out got %b want %b", nm, cc_out, x.cc);
                    end
                end
                if (x.chk_cnd) begin
                    checks++;
                    if (cnd !== x.cnd) begin
                        errors++;
                        $display("FAIL %s cnd got %b want %b", nm, cnd, x.cnd);
                    end
                end
`ifdef Y86_CC_TRACE_EN
                if (x.chk_cnt) begin
                    checks++;
                    if (br_total_cnt !== x.tot || br_taken_cnt !== x.tak) begin
                        errors++;
                        $display("FAIL %s counters got total=%0d taken=%0d want total=%0d taken=%0d",
                                 nm, br_total_cnt, br_taken_cnt, x.tot, x.tak);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; icode = '0; ifun = '0; aluA = '0; aluB = '0; valE = '0;

        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        step(0, 0, 4'h7, 4'h3, 0, 0, 0);     expect_cc("rst_je",   1, 3'b100, 1, 1'b1);
        step(0, 0, 4'h7, 4'h4, 0, 0, 0);     expect_cc("rst_jne",  1, 3'b100, 1, 1'b0);

        // addq overflow to negative
        step(0, 0, 4'h6, 4'h0, MAXP, 64'd1, MINN); expect_cc("addq_cyc", 1, 3'b100, 1, 1'b0);
        step(0, 0, 4'h7, 4'h2, 0, 0, 0);     expect_cc("add_jl",   1, 3'b011, 1, 1'b0);
        step(0, 0, 4'h7, 4'h1, 0, 0, 0);     expect_cc("add_jle",  1, 3'b011, 1, 1'b0);
        step(0, 0, 4'h7, 4'h6, 0, 0, 0);     expect_cc("add_jg",   1, 3'b011, 1, 1'b1);

        // subq equal, then subq overflow to positive
        step(0, 0, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        step(0, 0, 4'h7, 4'h3, 0, 0, 0);     expect_cc("sub_eq_je", 1, 3'b100, 1, 1'b1);
        step(0, 0, 4'h6, 4'h1, 64'd1, MINN, MAXP);
        step(0, 0, 4'h7, 4'h2, 0, 0, 0);     expect_cc("sub_of_jl", 1, 3'b001, 1, 1'b1);
        step(0, 0, 4'h7, 4'h5, 0, 0, 0);     expect_cc("sub_of_jge", 1, 3'b001, 1, 1'b0);

        // writes that must not update the flags
        step(0, 1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        step(0, 0, 4'h6, 4'h5, 64'd5, 64'd5, 64'd0); expect_cc("stall_hold", 1, 3'b001, 0, 1'b0);
        step(0, 0, 4'h4, 4'h0, 0, 0, 64'd0); expect_cc("bad_ifun",  1, 3'b001, 1, 1'b0);
        step(0, 0, 4'h2, 4'h7, 0, 0, 0);     expect_cc("icode4",    1, 3'b001, 1, 1'b0);
        step(0, 0, 4'h2, 4'h0, 0, 0, 0);     expect_cc("rrmovq",    1, 3'b001, 1, 1'b1);
        step(0, 1, 4'h2, 4'h4, 0, 0, 0);     expect_cc("cmovne_st", 1, 3'b001, 1, 1'b1);

        // reset beats a simultaneous andq
        step(1, 0, 4'h6, 4'h2, MINN, MINN, MINN);
        step(0, 0, 4'h6, 4'h2, MINN, MINN, MINN); expect_cc("rst_wins", 1, 3'b100, 1, 1'b0);
        step(0, 0, 4'h0, 4'h0, 0, 0, 0);     expect_cc("andq_010",  1, 3'b010, 1, 1'b0);
        step(0, 0, 4'h6, 4'h3, 64'd3, 64'd3, 64'd0);
        step(0, 0, 4'h7, 4'h4, 0, 0, 0);     expect_cc("xorq_jne",  1, 3'b100, 1, 1'b0);

`ifdef Y86_CC_TRACE_EN
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        step(0, 0, 4'h7, 4'h3, 0, 0, 0);     expect_cnt("cnt_zero", 0, 0);
        step(0, 0, 4'h7, 4'h4, 0, 0, 0);
        step(0, 0, 4'h7, 4'h3, 0, 0, 0);
        step(0, 1, 4'h7, 4'h3, 0, 0, 0);
        step(0, 0, 4'h0, 4'h0, 0, 0, 0);     expect_cnt("cnt_3_2", 4'd3, 4'd2);
        step(1, 0, 4'h0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 4'h7, 4'h0, 0, 0, 0);
        end
        step(0, 0, 4'h0, 4'h0, 0, 0, 0);     expect_cnt("cnt_sat", 4'd15, 4'd15);
`endif

        step(0, 0, 4'h0, 4'h0, 0, 0, 0);
        step(0, 0, 4'h0, 4'h0, 0, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_cc_unit.md
Name: y86_cc_unit

Overview:
- Sits at the consumer end of the ALU datapath in the Y86-64 single-cycle core.
- Takes the ALU operands (aluA, aluB) and the result valE, and computes ZF, SF and OF for OPq.
- Holds ZF/SF/OF in the condition-code register.
- Evaluates the branch/cmov condition `cnd` for jXX and cmovXX from the stored flags.
- Optional taken/total branch counters, compiled in by macro.

Parameters:
- W, 64, datapath width of aluA/aluB/valE.
- CNT_W, 32, width of branch trace counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- icode  in  4  current instruction code
- ifun  in  4  current function code
- aluA  in  W  ALU input A (valC, valA or constant 8, per ALU-A select)
- aluB  in  W  ALU input B
- valE  in  W  ALU result
- stall  in  1  1 = hold this cycle: no CC update, no counter update
- cc_out  out  3  registered flags {ZF,SF,OF}
- cnd  out  1  condition result for current icode/ifun
- br_taken_cnt  out  CNT_W  (CC_TRACE_EN only) taken jXX count
- br_total_cnt  out  CNT_W  (CC_TRACE_EN only) executed jXX count

Behaviour:
- Reset: rst high at a rising edge sets cc_out = 3'b100 (ZF=1, SF=0, OF=0). This applies regardless of stall or icode; reset wins over every simultaneous event.
- CC write enable: set_cc = (icode==6) && (ifun<=3) && !stall.
  - When set, cc_out updates at the next rising edge. The new flags are visible the cycle after the OPq.
  - icode 6 with ifun>3 (invalid op): no update.
- Flag computation (combinational, registered on set_cc):
  - ZF = (valE==0)
  - SF = valE[W-1]
  - OF by ifun:
    - addq (0), valE = aluB+aluA: OF = (aluA[W-1]==aluB[W-1]) && (valE[W-1]!=aluA[W-1])
    - subq (1), valE = aluB-aluA: OF = (aluA[W-1]!=aluB[W-1]) && (valE[W-1]!=aluB[W-1])
    - andq (2), xorq (3): OF = 0
- cnd: combinational from registered cc_out, never from the flags being computed this cycle. An OPq followed by a jXX uses the OPq's flags; an OPq in the same cycle does not affect cnd.
- cnd by ifun, valid for icode 2 (rrmovq/cmovXX) and 7 (jXX):
  - 0 always: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&&!ZF
  - 7..15: 0
- cnd = 0 for every other icode.
- stall does not affect cnd.
- Latency: 1 cycle from OPq to visible flags; 0 cycles from flags to cnd.
- No state besides the CC register (and counters when enabled).

Optional Feature:
- Macro: Y86_CC_TRACE_EN.
- When defined:
  - br_total_cnt increments on each edge where icode==7 && !stall && !rst.
  - br_taken_cnt increments on the same condition when cnd==1.
  - Both saturate at all-ones (no wrap) and clear to 0 on rst.
- When undefined: both ports and all counter logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IRRMOVQ=2, IOPQ=6, IJXX=7
  - ALU ifun constants: ALUADD=0, ALUSUB=1, ALUAND=2, ALUXOR=3
  - condition ifun constants: C_YES..C_G = 0..6
  - CC reset constant CC_RESET=3'b100
  - bit indices for ZF/SF/OF
- One sub-module: y86_cond_eval. Purely combinational, (cc, ifun) -> cond. It is reused by any future pipelined core.

Test Plan:
- Reset, then icode=7, ifun=3 (je) -> cc_out=100, cnd=1; icode=7, ifun=4 (jne) -> cnd=0.
- addq: aluA=64'h7FFF_FFFF_FFFF_FFFF, aluB=1, valE=64'h8000_0000_0000_0000, icode=6, ifun=0 -> next cycle cc_out=011; jl (ifun 2) cnd=0, jle cnd=0, jg cnd=1.
- subq: aluA=5, aluB=5, valE=0 -> cc_out=100. Then subq aluA=1, aluB=64'h8000_0000_0000_0000, valE=64'h7FFF_FFFF_FFFF_FFFF -> cc_out=001.
- Same OPq with stall=1 -> cc_out unchanged. icode=6, ifun=5 -> unchanged. icode=4 with valE=0 -> unchanged. cmov ifun=7 -> cnd=0.
- rst and an OPq producing cc 010 in the same cycle -> cc_out=100.
- With Y86_CC_TRACE_EN: 3 jXX cycles (taken, not taken, taken) plus one stalled jXX -> total=3, taken=2. Preload the counters to all-ones via 2^CNT_W jXX events at CNT_W=4 -> both hold at 15.
